// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package cpu_ctrl_pkg;

  localparam int unsigned STALL_W    = 6;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned EXC_W      = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

  // Hold masks: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_DIV      = 6'b001111;

  localparam int unsigned EXC_SYSCALL = 8;
  localparam int unsigned EXC_INVALID = 9;
  localparam int unsigned EXC_ERET    = 12;

  localparam logic [ADDR_W-1:0] DEFAULT_EXC_HANDLER = 32'hBFC00380;

  // ERET returns to EPC; every other exception enters the handler.
  function automatic logic [ADDR_W-1:0] exc_target(
    input logic [EXC_W-1:0]  exc,
    input logic [ADDR_W-1:0] epc,
    input logic [ADDR_W-1:0] handler
  );
    return exc[EXC_ERET] ? epc : handler;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator.
// Ports: ID operand read enables/addresses, EX load/write/destination in;
//        hazard out (1 when ID needs the result of the load in EX).
module load_use_detect
  import cpu_ctrl_pkg::*;
(
  input  logic                  id_reg1_read_i,
  input  logic                  id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
  input  logic                  ex_rmem_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  output logic                  hazard_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_reg1_read_i && (id_reg1_addr_i == ex_wd_i);
  assign rt_match = id_reg2_read_i && (id_reg2_addr_i == ex_wd_i);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard_o = ex_rmem_i && ex_wreg_i && (ex_wd_i != REG_ADDR_W'(0))
                    && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline.
// Ports: clk, rst (sync, active-high); ID operand requests, EX load/divide
//        status, divider ready, MEM exception vector, EPC in;
//        stall_o mask, flush_o, new_pc_o, div_cancel_o (combinational from
//        state and inputs), stall_cnt_o (registered cycle counter) out.
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_HANDLER_ADDR = DEFAULT_EXC_HANDLER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_reg1_read_i,
  input  logic                  id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
  input  logic                  ex_rmem_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_div_start_i,
  input  logic                  div_ready_i,
  input  logic [EXC_W-1:0]      mem_exception_i,
  input  logic [ADDR_W-1:0]     cp0_epc_i,
  output logic [STALL_W-1:0]    stall_o,
  output logic                  flush_o,
  output logic [ADDR_W-1:0]     new_pc_o,
  output logic                  div_cancel_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  ctrl_state_t state;
  ctrl_state_t next_state;
  logic        load_use;
  logic        exc_hit;

  load_use_detect u_load_use_detect (
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_rmem_i      (ex_rmem_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .hazard_o       (load_use)
  );

  assign exc_hit = |mem_exception_i;

  // State register and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      stall_cnt_o <= '0;
    end else begin
      state <= next_state;
      if ((stall_o != STALL_NONE) && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

  // Next state and control outputs; priority exception > divide > load-use.
  // Outputs are held quiet while rst is asserted so a reset never emits a
  // cancel or flush pulse.
  always_comb begin
    next_state   = state;
    stall_o      = STALL_NONE;
    flush_o      = 1'b0;
    new_pc_o     = '0;
    div_cancel_o = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (exc_hit) begin
            flush_o    = 1'b1;
            new_pc_o   = exc_target(mem_exception_i, cp0_epc_i, EXC_HANDLER_ADDR);
            next_state = FLUSH;
          end else if (ex_div_start_i && !div_ready_i) begin
            stall_o    = STALL_DIV;
            next_state = DIV_WAIT;
          end else if (load_use) begin
            stall_o = STALL_LOAD_USE;
          end
        end
        DIV_WAIT: begin
          if (exc_hit) begin
            flush_o      = 1'b1;
            new_pc_o     = exc_target(mem_exception_i, cp0_epc_i, EXC_HANDLER_ADDR);
            div_cancel_o = 1'b1;
            next_state   = FLUSH;
          end else if (!div_ready_i) begin
            stall_o = STALL_DIV;
          end else begin
            next_state = RUN;
          end
        end
        FLUSH: begin
          next_state = RUN;
        end
        default: begin
          next_state = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        id_reg1_read_i;
  logic        id_reg2_read_i;
  logic [4:0]  id_reg1_addr_i;
  logic [4:0]  id_reg2_addr_i;
  logic        ex_rmem_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic        ex_div_start_i;
  logic        div_ready_i;
  logic [31:0] mem_exception_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        div_cancel_o;
  logic [31:0] stall_cnt_o;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  pipeline_ctrl #(.EXC_HANDLER_ADDR(32'hBFC00380)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_read_i  (id_reg1_read_i),
    .id_reg2_read_i  (id_reg2_read_i),
    .id_reg1_addr_i  (id_reg1_addr_i),
    .id_reg2_addr_i  (id_reg2_addr_i),
    .ex_rmem_i       (ex_rmem_i),
    .ex_wreg_i       (ex_wreg_i),
    .ex_wd_i         (ex_wd_i),
    .ex_div_start_i  (ex_div_start_i),
    .div_ready_i     (div_ready_i),
    .mem_exception_i (mem_exception_i),
    .cp0_epc_i       (cp0_epc_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o),
    .div_cancel_o    (div_cancel_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic clear_inputs();
    id_reg1_read_i  = 1'b0;
    id_reg2_read_i  = 1'b0;
    id_reg1_addr_i  = 5'd0;
    id_reg2_addr_i  = 5'd0;
    ex_rmem_i       = 1'b0;
    ex_wreg_i       = 1'b0;
    ex_wd_i         = 5'd0;
    ex_div_start_i  = 1'b0;
    div_ready_i     = 1'b0;
    mem_exception_i = 32'd0;
    cp0_epc_i       = 32'd0;
  endtask

  task automatic set_load(input logic [4:0] wd);
    ex_rmem_i = 1'b1;
    ex_wreg_i = 1'b1;
    ex_wd_i   = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL rst_stall: got %b expected %b", stall_o, 6'b000000); end
    assert_cnt++; if (flush_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_flush: got %b expected 0", flush_o); end
    assert_cnt++; if (new_pc_o !== 32'h0) begin fail_cnt++; $display("FAIL rst_new_pc: got %h expected 00000000", new_pc_o); end
    assert_cnt++; if (div_cancel_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_cancel: got %b expected 0", div_cancel_o); end
    assert_cnt++; if (stall_cnt_o !== 32'd0) begin fail_cnt++; $display("FAIL rst_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

  task automatic test_load_use();
    do_reset();
    // lw $3 in EX, ID reads $3 through rs
    set_load(5'd3);
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd3;
    #1;
    assert_cnt++; if (stall_o !== 6'b000111) begin fail_cnt++; $display("FAIL lu_stall: got %b expected %b", stall_o, 6'b000111); end
    // bubble reaches EX, ID unchanged
    @(negedge clk);
    ex_rmem_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = 5'd0;
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL lu_release: got %b expected %b", stall_o, 6'b000000); end
    assert_cnt++; if (stall_cnt_o !== 32'd1) begin fail_cnt++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt_o); end
    // rt dependency on $17
    @(negedge clk);
    clear_inputs();
    set_load(5'd17);
    id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd17;
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd2;
    #1;
    assert_cnt++; if (stall_o !== 6'b000111) begin fail_cnt++; $display("FAIL lu_rt_stall: got %b expected %b", stall_o, 6'b000111); end
    @(negedge clk);
    clear_inputs();
    #1;
    assert_cnt++; if (stall_cnt_o !== 32'd2) begin fail_cnt++; $display("FAIL lu_rt_cnt: got %0d expected 2", stall_cnt_o); end
  endtask

  task automatic test_load_use_negative();
    do_reset();
    // load to $0 with matching rs read
    set_load(5'd0);
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd0;
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL lu_zero_reg: got %b expected %b", stall_o, 6'b000000); end
    // matching rt address but rt not read
    @(negedge clk);
    clear_inputs();
    set_load(5'd5);
    id_reg2_addr_i = 5'd5;
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL lu_no_read: got %b expected %b", stall_o, 6'b000000); end
    // ALU result (not a load) feeding ID: forwarded, no stall
    @(negedge clk);
    clear_inputs();
    ex_wreg_i = 1'b1; ex_wd_i = 5'd9;
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd9;
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL lu_not_load: got %b expected %b", stall_o, 6'b000000); end
    @(negedge clk);
    clear_inputs();
    #1;
    assert_cnt++; if (stall_cnt_o !== 32'd0) begin fail_cnt++; $display("FAIL lu_neg_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

  task automatic test_divide();
    int bad;
    do_reset();
    ex_div_start_i = 1'b1;
    div_ready_i    = 1'b0;
    // a load-use at the start cycle must yield the divide mask
    set_load(5'd4);
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd4;
    bad = 0;
    for (int i = 0; i < 33; i++) begin
      #1;
      assert_cnt++;
      if (stall_o !== 6'b001111) begin
        fail_cnt++; bad++;
        if (bad <= 3) $display("FAIL div_stall[%0d]: got %b expected %b", i, stall_o, 6'b001111);
      end
      @(negedge clk);
      if (i == 0) begin
        ex_rmem_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = 5'd0;
      end
    end
    div_ready_i = 1'b1;
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL div_ready: got %b expected %b", stall_o, 6'b000000); end
    @(negedge clk);
    clear_inputs();
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL div_after: got %b expected %b", stall_o, 6'b000000); end
    assert_cnt++; if (stall_cnt_o !== 32'd33) begin fail_cnt++; $display("FAIL div_cnt: got %0d expected 33", stall_cnt_o); end
  endtask

  task automatic test_div_ready_same_cycle();
    do_reset();
    ex_div_start_i = 1'b1;
    div_ready_i    = 1'b1;
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL div_fast_stall: got %b expected %b", stall_o, 6'b000000); end
    @(negedge clk);
    clear_inputs();
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL div_fast_next: got %b expected %b", stall_o, 6'b000000); end
    assert_cnt++; if (stall_cnt_o !== 32'd0) begin fail_cnt++; $display("FAIL div_fast_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

  task automatic test_syscall_in_div();
    do_reset();
    ex_div_start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ex_div_start_i = 1'b0;
    end
    mem_exception_i = 32'h0000_0100;
    cp0_epc_i       = 32'h8000_0040;
    #1;
    assert_cnt++; if (flush_o !== 1'b1) begin fail_cnt++; $display("FAIL sys_flush: got %b expected 1", flush_o); end
    assert_cnt++; if (div_cancel_o !== 1'b1) begin fail_cnt++; $display("FAIL sys_cancel: got %b expected 1", div_cancel_o); end
    assert_cnt++; if (new_pc_o !== 32'hBFC00380) begin fail_cnt++; $display("FAIL sys_new_pc: got %h expected bfc00380", new_pc_o); end
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL sys_stall: got %b expected %b", stall_o, 6'b000000); end
    // FLUSH cycle: exception still asserted and a load-use present, both ignored
    @(negedge clk);
    set_load(5'd8);
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd8;
    #1;
    assert_cnt++; if ({stall_o, flush_o, div_cancel_o} !== 8'd0) begin fail_cnt++; $display("FAIL flush_quiet: got stall=%b flush=%b cancel=%b expected all 0", stall_o, flush_o, div_cancel_o); end
    assert_cnt++; if (new_pc_o !== 32'h0) begin fail_cnt++; $display("FAIL flush_new_pc: got %h expected 00000000", new_pc_o); end
    assert_cnt++; if (stall_cnt_o !== 32'd10) begin fail_cnt++; $display("FAIL sys_cnt: got %0d expected 10", stall_cnt_o); end
    // back in RUN: the same load-use now stalls
    @(negedge clk);
    mem_exception_i = 32'd0;
    #1;
    assert_cnt++; if (stall_o !== 6'b000111) begin fail_cnt++; $display("FAIL post_flush_lu: got %b expected %b", stall_o, 6'b000111); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_eret();
    do_reset();
    mem_exception_i = 32'h0000_1000;
    cp0_epc_i       = 32'h8000_1234;
    set_load(5'd3);
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd3;
    #1;
    assert_cnt++; if (flush_o !== 1'b1) begin fail_cnt++; $display("FAIL eret_flush: got %b expected 1", flush_o); end
    assert_cnt++; if (new_pc_o !== 32'h80001234) begin fail_cnt++; $display("FAIL eret_new_pc: got %h expected 80001234", new_pc_o); end
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL eret_stall: got %b expected %b", stall_o, 6'b000000); end
    assert_cnt++; if (div_cancel_o !== 1'b0) begin fail_cnt++; $display("FAIL eret_cancel: got %b expected 0", div_cancel_o); end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    // invalid instruction in RUN goes to the handler, not EPC
    mem_exception_i = 32'h0000_0200;
    cp0_epc_i       = 32'h8000_5678;
    #1;
    assert_cnt++; if (new_pc_o !== 32'hBFC00380) begin fail_cnt++; $display("FAIL inv_new_pc: got %h expected bfc00380", new_pc_o); end
    assert_cnt++; if (flush_o !== 1'b1) begin fail_cnt++; $display("FAIL inv_flush: got %b expected 1", flush_o); end
    @(negedge clk);
    clear_inputs();
    #1;
    assert_cnt++; if (stall_cnt_o !== 32'd0) begin fail_cnt++; $display("FAIL eret_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

  task automatic test_reset_in_div();
    do_reset();
    ex_div_start_i = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    assert_cnt++; if (div_cancel_o !== 1'b0) begin fail_cnt++; $display("FAIL rdiv_no_cancel: got %b expected 0", div_cancel_o); end
    @(negedge clk);
    rst = 1'b0;
    ex_div_start_i = 1'b0;
    div_ready_i    = 1'b0;
    #1;
    assert_cnt++; if ({stall_o, flush_o, div_cancel_o} !== 8'd0) begin fail_cnt++; $display("FAIL rdiv_outputs: got stall=%b flush=%b cancel=%b expected all 0", stall_o, flush_o, div_cancel_o); end
    assert_cnt++; if (stall_cnt_o !== 32'd0) begin fail_cnt++; $display("FAIL rdiv_cnt: got %0d expected 0", stall_cnt_o); end
    @(negedge clk);
    #1;
    assert_cnt++; if (stall_o !== 6'b000000) begin fail_cnt++; $display("FAIL rdiv_idle: got %b expected %b", stall_o, 6'b000000); end
    @(negedge clk);
    ex_div_start_i = 1'b1;
    #1;
    assert_cnt++; if (stall_o !== 6'b001111) begin fail_cnt++; $display("FAIL rdiv_restart: got %b expected %b", stall_o, 6'b001111); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_load_use_negative();
    test_divide();
    test_div_ready_same_cycle();
    test_syscall_in_div();
    test_eret();
    test_reset_in_div();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
